// File: rtl/desc_dispatch_queue.sv
// Descriptor dispatch queue: dedups grants via a pending bitmap, queues indices in a FIFO,
// and issues them one at a time to an engine through an IDLE/ISSUE/WAIT handshake.
module desc_dispatch_queue #(
  parameter int unsigned MAX_DESC = 16,
  localparam int unsigned IDX_W = $clog2(MAX_DESC),
  localparam int unsigned CNT_W = IDX_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                gnt_vld,
  input  logic [IDX_W-1:0]    gnt_idx,
  output logic                disp_valid,
  output logic [IDX_W-1:0]    disp_idx,
  input  logic                disp_ready,
  input  logic                done_vld,
  output logic                cmpl_vld,
  output logic [IDX_W-1:0]    cmpl_idx,
  output logic [MAX_DESC-1:0] pending,
  output logic [CNT_W-1:0]    fifo_cnt,
  output logic                busy,
  output logic                dup_err,
  input  logic                clr_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t              state;
  logic [IDX_W-1:0]    mem [MAX_DESC];
  logic [IDX_W-1:0]    wr_ptr;
  logic [IDX_W-1:0]    rd_ptr;
  logic [IDX_W-1:0]    cur_idx;
  logic                push;
  logic                pop;
  logic                dup;
  logic                done_take;
  logic [MAX_DESC-1:0] pending_nxt;

  assign disp_idx = cur_idx;

  // A grant colliding with the same-cycle clear still sees the old set bit, so it is a duplicate.
  always_comb begin
    dup         = gnt_vld & pending[gnt_idx];
    push        = gnt_vld & ~pending[gnt_idx];
    pop         = (state == IDLE) && (fifo_cnt != '0);
    done_take   = (state == WAIT) && done_vld;
    pending_nxt = pending;
    if (done_take) pending_nxt[cur_idx] = 1'b0;
    if (push)      pending_nxt[gnt_idx] = 1'b1;
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      pending    <= '0;
      cur_idx    <= '0;
      disp_valid <= 1'b0;
      cmpl_vld   <= 1'b0;
      cmpl_idx   <= '0;
      dup_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      cmpl_vld <= 1'b0;
      if (push) wr_ptr <= wr_ptr + IDX_W'(1);
      if (pop)  rd_ptr <= rd_ptr + IDX_W'(1);
      if (dup)          dup_err <= 1'b1;
      else if (clr_err) dup_err <= 1'b0;

      case (state)
        IDLE: begin
          if (pop) begin
            cur_idx    <= mem[rd_ptr];
            disp_valid <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (disp_ready) begin
            disp_valid <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (done_vld) begin
            cmpl_vld <= 1'b1;
            cmpl_idx <= cur_idx;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          disp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_desc_dispatch_queue.sv
// Bench for desc_dispatch_queue: fixed vector table, directed corner sequences and a
// randomized run, all checked against a queue-based reference model.
module tb_desc_dispatch_queue;
  localparam int unsigned MAX_DESC = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int unsigned CNT_W    = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                gnt_vld = 1'b0;
  logic [IDX_W-1:0]    gnt_idx = '0;
  logic                disp_valid;
  logic [IDX_W-1:0]    disp_idx;
  logic                disp_ready = 1'b0;
  logic                done_vld = 1'b0;
  logic                cmpl_vld;
  logic [IDX_W-1:0]    cmpl_idx;
  logic [MAX_DESC-1:0] pending;
  logic [CNT_W-1:0]    fifo_cnt;
  logic                busy;
  logic                dup_err;
  logic                clr_err = 1'b0;

  always #5 clk = ~clk;

  desc_dispatch_queue #(.MAX_DESC(MAX_DESC)) dut (
    .clk(clk), .rst_n(rst_n), .gnt_vld(gnt_vld), .gnt_idx(gnt_idx),
    .disp_valid(disp_valid), .disp_idx(disp_idx), .disp_ready(disp_ready),
    .done_vld(done_vld), .cmpl_vld(cmpl_vld), .cmpl_idx(cmpl_idx),
    .pending(pending), .fifo_cnt(fifo_cnt), .busy(busy),
    .dup_err(dup_err), .clr_err(clr_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of waiting indices, one optional in-flight descriptor.
  int mq[$];
  bit mpend[MAX_DESC];
  int mcur   = -1;
  bit moffer = 0;
  bit mcmpl  = 0;
  int mcidx  = 0;
  bit mdup   = 0;
  int cmpl_log[$];

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [MAX_DESC-1:0] model_pending();
    logic [MAX_DESC-1:0] b = '0;
    for (int i = 0; i < int'(MAX_DESC); i++) b[i] = mpend[i];
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < int'(MAX_DESC); i++) mpend[i] = 0;
    mcur = -1; moffer = 0; mcmpl = 0; mcidx = 0; mdup = 0;
  endtask

  task automatic model_step(bit gv, int gi, bit rdy, bit done, bit clr);
    bit d, p;
    d = gv && mpend[gi];
    p = gv && !mpend[gi];
    mcmpl = 0;
    if (mcur < 0) begin
      if (mq.size() > 0) begin
        mcur   = mq.pop_front();
        moffer = 1;
      end
    end else if (moffer) begin
      if (rdy) moffer = 0;
    end else if (done) begin
      mcmpl        = 1;
      mcidx        = mcur;
      mpend[mcur]  = 0;
      mcur         = -1;
    end
    if (p) begin
      mq.push_back(gi);
      mpend[gi] = 1;
    end
    if (d)        mdup = 1;
    else if (clr) mdup = 0;
  endtask

  task automatic compare_model();
    bit ev;
    ev = (mcur >= 0) && moffer;
    chk("disp_valid", disp_valid, ev);
    if (ev) chk("disp_idx", disp_idx, mcur);
    chk("fifo_cnt", fifo_cnt, mq.size());
    chk("busy", busy, mcur >= 0);
    chk("cmpl_vld", cmpl_vld, mcmpl);
    if (mcmpl) chk("cmpl_idx", cmpl_idx, mcidx);
    chk("pending", pending, model_pending());
    chk("dup_err", dup_err, mdup);
    if (cmpl_vld) cmpl_log.push_back(int'(cmpl_idx));
  endtask

  task automatic cyc(bit gv, int gi, bit rdy, bit done, bit clr);
    @(negedge clk);
    gnt_vld = gv; gnt_idx = IDX_W'(gi); disp_ready = rdy; done_vld = done; clr_err = clr;
    @(posedge clk);
    model_step(gv, gi, rdy, done, clr);
    #1 compare_model();
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    gnt_vld = 0; gnt_idx = '0; disp_ready = 0; done_vld = 0; clr_err = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_idx", disp_idx, 0);
    chk("rst_cmpl_vld", cmpl_vld, 0);
    chk("rst_cmpl_idx", cmpl_idx, 0);
    chk("rst_pending", pending, 0);
    chk("rst_fifo_cnt", fifo_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dup_err", dup_err, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit gv; int gi; bit rdy; bit done; bit clr;
    bit ev; int eidx; int ecnt; bit ebusy; bit ecmpl; int ecidx; bit epend3;
  } vec_t;

  vec_t tbl[6];
  int   cnt7;

  initial begin
    // grant 3 at N with ready tied high: dispatch at N+2, done at N+4, completion at N+5
    tbl[0] = '{1, 3, 1, 0, 0,  0, 0, 1, 0, 0, 0, 1};
    tbl[1] = '{0, 0, 1, 0, 0,  1, 3, 0, 1, 0, 0, 1};
    tbl[2] = '{0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 1};
    tbl[3] = '{0, 0, 1, 0, 0,  0, 0, 0, 1, 0, 0, 1};
    tbl[4] = '{0, 0, 1, 1, 0,  0, 0, 0, 0, 1, 3, 0};
    tbl[5] = '{0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0};

    do_reset();

    foreach (tbl[i]) begin
      cyc(tbl[i].gv, tbl[i].gi, tbl[i].rdy, tbl[i].done, tbl[i].clr);
      chk("tbl_disp_valid", disp_valid, tbl[i].ev);
      if (tbl[i].ev) chk("tbl_disp_idx", disp_idx, tbl[i].eidx);
      chk("tbl_fifo_cnt", fifo_cnt, tbl[i].ecnt);
      chk("tbl_busy", busy, tbl[i].ebusy);
      chk("tbl_cmpl_vld", cmpl_vld, tbl[i].ecmpl);
      if (tbl[i].ecmpl) chk("tbl_cmpl_idx", cmpl_idx, tbl[i].ecidx);
      chk("tbl_pending3", pending[3], tbl[i].epend3);
    end

    // grants 5,2,9 with engine stalled; second grant overlaps the first pop
    cyc(1, 5, 0, 0, 0);
    cyc(1, 2, 0, 0, 0);
    chk("pushpop_cnt", fifo_cnt, 1);
    cyc(1, 9, 0, 0, 0);
    chk("stall_cnt", fifo_cnt, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("stall_valid", disp_valid, 1);
      chk("stall_idx", disp_idx, 5);
    end
    cmpl_log.delete();
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, 1, 0);
    chk("order_n", cmpl_log.size(), 3);
    if (cmpl_log.size() == 3) begin
      chk("order_0", cmpl_log[0], 5);
      chk("order_1", cmpl_log[1], 2);
      chk("order_2", cmpl_log[2], 9);
    end

    // duplicate grant of a pending index
    cmpl_log.delete();
    cyc(1, 7, 0, 0, 0);
    cyc(1, 7, 0, 0, 0);
    chk("dup_set", dup_err, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("dup_sticky", dup_err, 1);
    cyc(0, 0, 0, 0, 1);
    chk("dup_clr", dup_err, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 0);
    cnt7 = 0;
    foreach (cmpl_log[i]) if (cmpl_log[i] == 7) cnt7++;
    chk("dup_one_cmpl", cnt7, 1);

    // grant arriving in the same cycle its index is being cleared
    cyc(1, 4, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 4, 1, 1, 1);
    chk("clr_race_dup", dup_err, 1);
    chk("clr_race_pend", pending[4], 0);
    chk("clr_race_cnt", fifo_cnt, 0);
    cyc(0, 0, 0, 0, 1);

    // fill all slots with engine stalled, then drain across pointer wrap
    for (int i = 0; i < 16; i++) cyc(1, (i * 5) % 16, 0, 0, 0);
    chk("full_cnt", fifo_cnt, 15);
    chk("full_pending", pending, 16'hFFFF);
    chk("full_busy", busy, 1);
    cmpl_log.delete();
    for (int i = 0; i < 60; i++) cyc(0, 0, 1, 1, 0);
    chk("drain_n", cmpl_log.size(), 16);
    if (cmpl_log.size() == 16)
      for (int k = 0; k < 16; k++) chk("drain_order", cmpl_log[k], (k * 5) % 16);
    chk("drain_cnt", fifo_cnt, 0);

    // reset while waiting on the engine with three entries queued
    cyc(1, 1, 1, 0, 0);
    cyc(1, 2, 1, 0, 0);
    cyc(1, 3, 1, 0, 0);
    cyc(1, 6, 1, 0, 0);
    chk("wait_busy", busy, 1);
    chk("wait_cnt", fifo_cnt, 3);
    chk("wait_valid", disp_valid, 0);
    do_reset();
    cmpl_log.delete();
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 1, 0);
    chk("post_rst_no_cmpl", cmpl_log.size(), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom_range(0, 1) == 1,
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/desc_dispatch_queue.md
DESC_DISPATCH_QUEUE -- requirements
Module: desc_dispatch_queue

Interface
REQ-001 SHALL have parameter MAX_DESC, default 16: number of descriptor slots; range 2..16, power of two.
REQ-002 SHALL have localparam IDX_W = CLOG2(MAX_DESC): index width. CNT_W = IDX_W+1: occupancy width.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port gnt_vld, input, 1: one-cycle grant pulse from the upstream grant controller.
REQ-006 SHALL have port gnt_idx, input, IDX_W: granted descriptor index; valid only with gnt_vld.
REQ-007 SHALL have port disp_valid, output, 1: a dispatch command is offered.
REQ-008 SHALL have port disp_idx, output, IDX_W: descriptor index of the offered command.
REQ-009 SHALL have port disp_ready, input, 1: the engine accepts the command.
REQ-010 SHALL have port done_vld, input, 1: one-cycle pulse; the engine finished the accepted command.
REQ-011 SHALL have port cmpl_vld, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port cmpl_idx, output, IDX_W: index of the completed descriptor.
REQ-013 SHALL have port pending, output, MAX_DESC: bitmap of descriptors that are queued or in flight.
REQ-014 SHALL have port fifo_cnt, output, CNT_W: number of queued entries, excluding the in-flight entry.
REQ-015 SHALL have port busy, output, 1: FSM is not in IDLE.
REQ-016 SHALL have port dup_err, output, 1: sticky error flag for a dropped duplicate grant.
REQ-017 SHALL have port clr_err, input, 1: synchronous clear of dup_err.

Function
REQ-018 SHALL implement a FIFO with depth MAX_DESC that holds IDX_W-bit indices, using wrapping read and write pointers plus an occupancy counter.
REQ-019 SHALL push gnt_idx on gnt_vld when pending[gnt_idx]==0, and in that cycle set pending[gnt_idx] to 1; the entry is visible in fifo_cnt on the next cycle.
REQ-020 SHALL drop gnt_vld when pending[gnt_idx]==1 (no push, FIFO unchanged) and set dup_err to 1.
REQ-021 SHALL make FIFO overflow unreachable through the pending bitmap (at most MAX_DESC distinct indices); the push logic needs no full-drop path.
REQ-022 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-023 SHALL, in IDLE with fifo_cnt>0, pop the head into cur_idx and go to ISSUE; pop is the only exit from IDLE.
REQ-024 SHALL, in ISSUE, drive disp_valid=1 and disp_idx=cur_idx; on disp_ready=1 go to WAIT.
REQ-025 SHALL hold disp_valid and disp_idx stable in ISSUE until disp_ready; disp_valid is 0 in all other states.
REQ-026 SHALL, in WAIT on done_vld=1, pulse cmpl_vld=1 with cmpl_idx=cur_idx on the next cycle, clear pending[cur_idx] in that same next cycle, and return to IDLE.
REQ-027 SHALL ignore done_vld outside WAIT.
REQ-028 SHALL give a latency of 2 cycles from gnt_vld (cycle N, FIFO empty, FSM IDLE) to disp_valid (cycle N+2).
REQ-029 SHALL, on a simultaneous push and pop, perform both and leave fifo_cnt unchanged.
REQ-030 SHALL let the write and read pointers wrap from MAX_DESC-1 to 0.
REQ-031 SHALL, when a pending clear and a grant of the same index occur in the same cycle, treat the grant as a duplicate: drop it and set dup_err.
REQ-032 SHALL give set priority over clr_err when both affect dup_err in the same cycle.
REQ-033 SHALL drive busy=1 in ISSUE and WAIT.

Reset
REQ-034 SHALL, on rst_n=0 at any time (including mid-transaction), asynchronously force: FSM=IDLE; pointers=0; fifo_cnt=0; pending=0; disp_valid=0; disp_idx=0; cmpl_vld=0; cmpl_idx=0; dup_err=0; busy=0.
REQ-035 SHALL abandon in-flight and queued descriptors on reset, with no cmpl_vld pulse for them.

Verification
REQ-036 SHALL cover: gnt_vld idx=3 at cycle N, disp_ready=1 tied -> disp_valid/disp_idx=3 at N+2; done_vld at N+4 -> cmpl_vld, cmpl_idx=3 at N+5; pending[3]=0 at N+5.
REQ-037 SHALL cover: grants 5,2,9 on consecutive cycles, disp_ready held 0 -> fifo_cnt reaches 2, disp_idx=5 held stable; then dispatch order 5,2,9.
REQ-038 SHALL cover: grant idx=7 twice while 7 is pending -> second grant dropped, dup_err=1 until clr_err; only one completion for idx 7.
REQ-039 SHALL cover: all 16 indices granted with the engine stalled -> fifo_cnt=15 plus 1 in flight, pending=16'hFFFF; drain with wrap-around -> 16 completions in grant order; fifo_cnt=0.
REQ-040 SHALL cover: rst_n asserted while in WAIT with 3 entries queued -> all outputs at reset values immediately; no cmpl_vld after release.
REQ-041 SHALL cover: push and pop in the same cycle at fifo_cnt=1 -> fifo_cnt stays 1 and the correct head index is dispatched.
